// File: rtl/rpn_pkg.sv
// Shared types and key-to-token encoding for the RPN keypad front end.
package rpn_pkg;

    typedef struct packed {
        logic       is_op;
        logic [3:0] data;
    } token_t;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;

    // idx = row*4 + col; rows top to bottom: "1 2 3 A", "4 5 6 B", "7 8 9 C", "* 0 # D"
    function automatic token_t key_to_token(input logic [3:0] idx);
        token_t t;
        t.is_op = 1'b0;
        t.data  = 4'd0;
        case (idx)
            4'd0:  t.data = 4'd1;
            4'd1:  t.data = 4'd2;
            4'd2:  t.data = 4'd3;
            4'd3:  begin t.is_op = 1'b1; t.data = OP_ADD; end
            4'd4:  t.data = 4'd4;
            4'd5:  t.data = 4'd5;
            4'd6:  t.data = 4'd6;
            4'd7:  begin t.is_op = 1'b1; t.data = OP_SUB; end
            4'd8:  t.data = 4'd7;
            4'd9:  t.data = 4'd8;
            4'd10: t.data = 4'd9;
            4'd11: begin t.is_op = 1'b1; t.data = OP_MUL; end
            4'd12: begin t.is_op = 1'b1; t.data = OP_OR;  end
            4'd13: t.data = 4'd0;
            4'd14: begin t.is_op = 1'b1; t.data = OP_XOR; end
            default: begin t.is_op = 1'b1; t.data = OP_AND; end
        endcase
        return t;
    endfunction

endpackage

// File: rtl/rpn_keypad_frontend_if.sv
// Token strobe/ack handshake toward the calculator input port.
interface rpn_keypad_frontend_if;
    logic       output_stb;
    logic [3:0] output_data;
    logic       output_is_operator;
    logic       output_ack;

    modport master (
        output output_stb,
        output output_data,
        output output_is_operator,
        input  output_ack
    );

    modport slave (
        input  output_stb,
        input  output_data,
        input  output_is_operator,
        output output_ack
    );
endinterface

// File: rtl/rpn_token_fifo.sv
// Small register-based token FIFO; a push while full succeeds only if a pop frees a slot that cycle.
module rpn_token_fifo
    import rpn_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  token_t push_token,
    input  logic   pop,
    output token_t head,
    output logic   empty,
    output logic   full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    token_t         mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           wr_en;
    logic           rd_en;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= push_token;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
    end

endmodule

// File: rtl/rpn_keypad_frontend.sv
// 4x4 keypad scanner with per-frame debounce, token encoding and a buffered strobe/ack output.
module rpn_keypad_frontend
    import rpn_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 1000,
    parameter int unsigned DEBOUNCE_FRAMES = 4,
    parameter int unsigned DEPTH           = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3:0]             row_n,
    output logic [3:0]             col_n,
    rpn_keypad_frontend_if.master  tok,
    output logic                   overflow
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_FRAMES + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PRESS   = 2'd1;
    localparam logic [1:0] S_HELD    = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    logic [3:0]       row_meta;
    logic [3:0]       row_sync;
    logic [DIV_W-1:0] div;
    logic [1:0]       col_idx;
    logic             col_end;
    logic             frame_end;

    logic [2:0]       hits;
    logic [1:0]       hit_row;
    logic [1:0]       acc_cnt;
    logic [3:0]       acc_idx;
    logic [1:0]       m_cnt;
    logic [3:0]       m_idx;

    logic [1:0]       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       cand, cand_n;
    logic             push_n;
    logic             push_q;
    token_t           push_tok_q;

    token_t           head;
    logic             empty;
    logic             full;
    logic             pop;

    // Rows are asynchronous to clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row_n;
            row_sync <= row_meta;
        end
    end

    assign col_end   = (div == DIV_W'(SCAN_DIV - 1));
    assign frame_end = col_end && (col_idx == 2'd3);

    // Column scan: each column is driven low for SCAN_DIV cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div     <= '0;
            col_idx <= 2'd0;
            col_n   <= 4'b1110;
        end else if (col_end) begin
            div     <= '0;
            col_idx <= col_idx + 2'd1;
            col_n   <= {col_n[2:0], col_n[3]};
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    // Merge this column's rows into the running frame tally (0, 1 or 2 = "many").
    always_comb begin
        hits    = 3'd0;
        hit_row = 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (!row_sync[r]) begin
                hits    = hits + 3'd1;
                hit_row = 2'(r);
            end
        end
        m_cnt = acc_cnt;
        m_idx = acc_idx;
        if (hits == 3'd1 && acc_cnt == 2'd0) begin
            m_cnt = 2'd1;
            m_idx = {hit_row, col_idx};
        end else if (hits != 3'd0) begin
            m_cnt = 2'd2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_cnt <= 2'd0;
            acc_idx <= 4'd0;
        end else if (frame_end) begin
            acc_cnt <= 2'd0;
            acc_idx <= 4'd0;
        end else if (col_end) begin
            acc_cnt <= m_cnt;
            acc_idx <= m_idx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            cand  <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            cand  <= cand_n;
        end
    end

    // Debounce FSM, advanced only on the frame-end cycle.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cand_n  = cand;
        push_n  = 1'b0;
        if (frame_end) begin
            case (state)
                S_IDLE: begin
                    if (m_cnt == 2'd1) begin
                        cand_n = m_idx;
                        cnt_n  = CNT_W'(1);
                        if (DEBOUNCE_FRAMES == 1) begin
                            push_n  = 1'b1;
                            state_n = S_HELD;
                        end else begin
                            state_n = S_PRESS;
                        end
                    end
                end
                S_PRESS: begin
                    if (m_cnt == 2'd1 && m_idx == cand) begin
                        cnt_n = cnt + CNT_W'(1);
                        if (cnt_n == CNT_W'(DEBOUNCE_FRAMES)) begin
                            push_n  = 1'b1;
                            state_n = S_HELD;
                        end
                    end else begin
                        cnt_n   = '0;
                        state_n = S_IDLE;
                    end
                end
                S_HELD: begin
                    if (m_cnt == 2'd0) begin
                        cnt_n   = CNT_W'(1);
                        state_n = (DEBOUNCE_FRAMES == 1) ? S_IDLE : S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (m_cnt == 2'd0) begin
                        cnt_n = cnt + CNT_W'(1);
                        if (cnt_n == CNT_W'(DEBOUNCE_FRAMES)) begin
                            cnt_n   = '0;
                            state_n = S_IDLE;
                        end
                    end else begin
                        state_n = S_HELD;
                    end
                end
                default: begin
                    cnt_n   = '0;
                    state_n = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            push_q     <= 1'b0;
            push_tok_q <= '0;
        end else begin
            push_q <= push_n;
            if (push_n) begin
                push_tok_q <= key_to_token(cand_n);
            end
        end
    end

    assign pop = !empty && tok.output_ack;

    rpn_token_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push_q),
        .push_token (push_tok_q),
        .pop        (pop),
        .head       (head),
        .empty      (empty),
        .full       (full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (push_q && full && !pop) begin
            overflow <= 1'b1;
        end
    end

    assign tok.output_stb         = !empty;
    assign tok.output_data        = head.data;
    assign tok.output_is_operator = head.is_op;

endmodule

// File: tb/tb_rpn_keypad_frontend.sv
// Directed bench: keypad model drives row_n from a pressed-key mask and the scanned col_n.
module tb_rpn_keypad_frontend;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic        overflow;
    logic [15:0] pressed;

    int checks = 0;
    int errors = 0;
    int stb_cycles = 0;
    logic [4:0] xq[$];

    rpn_keypad_frontend_if tok_if ();

    rpn_keypad_frontend #(
        .SCAN_DIV        (4),
        .DEBOUNCE_FRAMES (2),
        .DEPTH           (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .row_n    (row_n),
        .col_n    (col_n),
        .tok      (tok_if.master),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row_n[r] = !(|(pressed[r*4 +: 4] & ~col_n));
        end
    end

    always @(negedge clk) begin
        if (rst && tok_if.output_stb) begin
            stb_cycles++;
            if (tok_if.output_ack) xq.push_back({tok_if.output_is_operator, tok_if.output_data});
        end
    end

    typedef struct {
        int         key;
        int         hold;
        logic       exp_is_op;
        logic [3:0] exp_data;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Returns #1 after the edge that starts a new frame (column 0 driven).
    task automatic align_frame();
        logic [3:0] prev;
        bit found;
        found = 1'b0;
        prev  = col_n;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk); #1;
            if (prev == 4'b0111 && col_n == 4'b1110) found = 1'b1;
            prev = col_n;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL align_frame timeout col_n=%b", col_n);
        end
    endtask

    task automatic press_keys(input logic [15:0] k, input int hold, input int rel);
        align_frame();
        pressed = k;
        repeat (hold) align_frame();
        pressed = '0;
        repeat (rel) align_frame();
    endtask

    task automatic check_tokens(input string name, input logic [4:0] exp[$]);
        check({name, "_count"}, xq.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < xq.size()) check({name, "_tok"}, int'(xq[i]), int'(exp[i]));
        end
    endtask

    initial begin
        logic [4:0] exp_q[$];
        int bad;

        vecs[0]  = '{5,  6, 1'b0, 4'd5};
        vecs[1]  = '{0,  3, 1'b0, 4'd1};
        vecs[2]  = '{1,  3, 1'b0, 4'd2};
        vecs[3]  = '{2,  3, 1'b0, 4'd3};
        vecs[4]  = '{3,  3, 1'b1, 4'd0};
        vecs[5]  = '{4,  3, 1'b0, 4'd4};
        vecs[6]  = '{6,  3, 1'b0, 4'd6};
        vecs[7]  = '{7,  3, 1'b1, 4'd1};
        vecs[8]  = '{8,  3, 1'b0, 4'd7};
        vecs[9]  = '{9,  3, 1'b0, 4'd8};
        vecs[10] = '{10, 3, 1'b0, 4'd9};
        vecs[11] = '{11, 3, 1'b1, 4'd2};
        vecs[12] = '{12, 3, 1'b1, 4'd4};
        vecs[13] = '{13, 3, 1'b0, 4'd0};
        vecs[14] = '{14, 3, 1'b1, 4'd5};
        vecs[15] = '{15, 4, 1'b1, 4'd3};

        pressed = '0;
        tok_if.output_ack = 1'b1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_col_n", int'(col_n), 4'b1110);
        check("rst_stb", int'(tok_if.output_stb), 0);
        check("rst_data", int'(tok_if.output_data), 0);
        check("rst_is_op", int'(tok_if.output_is_operator), 0);
        check("rst_overflow", int'(overflow), 0);
        rst = 1'b1;

        // Every key with ack held high: one transfer of one cycle per press.
        for (int i = 0; i < 16; i++) begin
            xq.delete();
            stb_cycles = 0;
            press_keys(16'(1) << vecs[i].key, vecs[i].hold, 3);
            check($sformatf("key%0d_count", vecs[i].key), xq.size(), 1);
            if (xq.size() > 0)
                check($sformatf("key%0d_tok", vecs[i].key), int'(xq[0]),
                      int'({vecs[i].exp_is_op, vecs[i].exp_data}));
            check($sformatf("key%0d_stb_cycles", vecs[i].key), stb_cycles, 1);
        end
        check("overflow_after_keys", int'(overflow), 0);

        // Operator 'A' held on the interface while ack is low.
        tok_if.output_ack = 1'b0;
        xq.delete();
        press_keys(16'h0008, 3, 3);
        check("a_stb", int'(tok_if.output_stb), 1);
        check("a_data", int'(tok_if.output_data), 0);
        check("a_is_op", int'(tok_if.output_is_operator), 1);
        bad = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (tok_if.output_stb !== 1'b1 || tok_if.output_data !== 4'd0 ||
                tok_if.output_is_operator !== 1'b1) bad++;
        end
        check("a_stable_bad_cycles", bad, 0);
        tok_if.output_ack = 1'b1;
        @(posedge clk); #1;
        tok_if.output_ack = 1'b0;
        check("a_stb_after_ack", int'(tok_if.output_stb), 0);
        exp_q = '{5'h10};
        check_tokens("a_xfer", exp_q);

        // Bouncing '7' must not produce a token; a steady hold does.
        tok_if.output_ack = 1'b1;
        xq.delete();
        align_frame();
        pressed = 16'h0100; align_frame();
        pressed = '0;       align_frame();
        pressed = 16'h0100; align_frame();
        pressed = '0;       align_frame(); align_frame();
        check("bounce_no_token", xq.size(), 0);
        press_keys(16'h0100, 3, 3);
        exp_q = '{5'h07};
        check_tokens("bounce_hold", exp_q);

        // Two keys together are rejected until only one remains.
        xq.delete();
        stb_cycles = 0;
        align_frame();
        pressed = 16'h0003;
        repeat (5) align_frame();
        check("multi_no_token", xq.size(), 0);
        check("multi_fifo_empty", stb_cycles, 0);
        pressed = 16'h0001;
        repeat (3) align_frame();
        pressed = '0;
        repeat (3) align_frame();
        exp_q = '{5'h01};
        check_tokens("multi_then_one", exp_q);

        // Five presses into a four-deep FIFO with ack low.
        tok_if.output_ack = 1'b0;
        xq.delete();
        press_keys(16'h0001, 3, 3);
        press_keys(16'h0002, 3, 3);
        press_keys(16'h0004, 3, 3);
        check("ovf_not_yet", int'(overflow), 0);
        press_keys(16'h0010, 3, 3);
        press_keys(16'h0020, 3, 3);
        check("ovf_set", int'(overflow), 1);
        tok_if.output_ack = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        exp_q = '{5'h01, 5'h02, 5'h03, 5'h04};
        check_tokens("ovf_drain", exp_q);
        check("ovf_stb_drained", int'(tok_if.output_stb), 0);
        check("ovf_sticky", int'(overflow), 1);

        // Reset mid-frame with tokens queued and a press in progress.
        tok_if.output_ack = 1'b0;
        press_keys(16'h0001, 3, 3);
        press_keys(16'h0002, 3, 3);
        check("rq_stb", int'(tok_if.output_stb), 1);
        align_frame();
        pressed = 16'h0004;
        align_frame();
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        check("rq_rst_stb", int'(tok_if.output_stb), 0);
        check("rq_rst_col_n", int'(col_n), 4'b1110);
        check("rq_rst_overflow", int'(overflow), 0);
        repeat (3) @(posedge clk);
        #1;
        pressed = '0;
        rst = 1'b1;
        tok_if.output_ack = 1'b1;
        xq.delete();
        repeat (6) align_frame();
        check("rq_no_stale", xq.size(), 0);
        check("rq_overflow_clear", int'(overflow), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rpn_keypad_frontend.md
Name: rpn_keypad_frontend

Overview:
Upstream input stage for the RPN calculator. It scans a 4x4 matrix keypad, debounces presses and encodes each press into one token (a 4-bit value plus an operand/operator flag). Tokens are buffered in a small FIFO and delivered on a strobe/ack handshake that connects directly to the calculator's input_stb/input_data/is_input_operator/input_ack ports.

Parameters:
SCAN_DIV, 1000, clock cycles each column is driven; must be >= 4.
DEBOUNCE_FRAMES, 4, consecutive identical scan frames required to accept a press or a release; must be >= 1.
DEPTH, 4, token FIFO depth; must be a power of 2 and >= 2.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
row_n  in  4  keypad rows, active-low, pulled up externally, asynchronous to clk
col_n  out  4  keypad column drive, one-hot active-low
output_stb  out  1  token valid; connects to calculator input_stb
output_data  out  4  token value; connects to input_data
output_is_operator  out  1  1 = operator, 0 = operand digit; connects to is_input_operator
output_ack  in  1  token accepted; connects to input_ack
overflow  out  1  sticky: a token was dropped because the FIFO was full

Behaviour:
- Reset (rst low, asynchronous): col_n=4'b1110, column index 0, divider 0, debounce FSM IDLE, counters 0, FIFO empty, output_stb=0, output_data=0, output_is_operator=0, overflow=0. overflow clears only on reset.
- Scanning: column c is driven for SCAN_DIV cycles, then c -> c+1 mod 4. One frame is 4*SCAN_DIV cycles.
- row_n passes through a 2-FF synchronizer. Rows are sampled on the last cycle of each column window.
- Key index is r*4+c.
- Frame result is computed at the end of the column-3 window:
  - valid: exactly one key seen over the whole frame.
  - none: no keys seen.
  - multi: two or more keys seen; multi is treated as invalid.
- Key map, rows top to bottom:
  - Row 0: 1 2 3 A
  - Row 1: 4 5 6 B
  - Row 2: 7 8 9 C
  - Row 3: * 0 # D
- Digits produce is_op=0 with data equal to the digit.
- Operators produce is_op=1: A=OP_ADD(0), B=OP_SUB(1), C=OP_MUL(2), D=OP_AND(3), *=OP_OR(4), #=OP_XOR(5).
- Debounce FSM, evaluated once per frame:
  - IDLE: on valid, cand=idx, cnt=1, go to PRESS. If DEBOUNCE_FRAMES=1, push the token immediately and go to HELD.
  - PRESS:
    - valid with idx==cand: cnt++. When cnt reaches DEBOUNCE_FRAMES, push token(cand) and go to HELD.
    - Any other result: go to IDLE with cnt=0 (no restart on a different key in the same frame).
  - HELD: on none, cnt=1 and go to RELEASE. Otherwise stay; keys are ignored until all are released.
  - RELEASE:
    - none: cnt++. When cnt reaches DEBOUNCE_FRAMES, go to IDLE.
    - Any key or multi: go to HELD.
  - Exactly one token is produced per debounced press; auto-repeat is never produced.
- FIFO:
  - Push when not full: store the token.
  - Push when full and no pop in the same cycle: drop the token and set overflow=1.
  - Push and pop in the same cycle while full: both succeed.
  - Pointers wrap modulo DEPTH.
- Handshake:
  - output_stb = FIFO not empty.
  - output_data and output_is_operator present the FIFO head. They stay stable while output_stb=1 and output_ack=0.
  - A transfer occurs on a cycle with output_stb&&output_ack. The head pops at that edge, and the next token (if any) is presented on the following cycle.
  - output_ack while output_stb=0 is ignored.
- Latency: a token appears on output_stb one cycle after the frame-end edge that completes debounce, provided the FIFO was empty.

Decomposition:
- Package rpn_pkg:
  - typedef token_t {logic is_op; logic [3:0] data;}
  - opcode localparams OP_ADD..OP_XOR
  - function key_to_token(idx), implementing the key map.
- Sub-module rpn_token_fifo (parameter DEPTH; push/token in; pop; head/empty/full out).
- Scanner and debounce logic stay in the top level.

Test Plan:
(All scenarios use SCAN_DIV=4, DEBOUNCE_FRAMES=2, frame = 16 cycles.)
- Hold key '5' (row 1, col 1) for 6 frames, then release, with output_ack tied 1 -> exactly one transfer with data=5, is_op=0; output_stb is high for 1 cycle; overflow=0.
- Press 'A' with output_ack=0 -> output_stb=1, data=0, is_op=1, all stable for 100 cycles; pulse output_ack for 1 cycle -> output_stb=0 on the next cycle.
- Bounce on '7' (present 1 frame, absent 1, present 1, absent 2) -> no token; then hold 3 frames -> one token, data=7.
- Hold '1' and '2' together for 5 frames -> no token and FIFO stays empty; release '2' while '1' stays held 3 more frames -> one token, data=1.
- output_ack=0; press/release 1,2,3,4,5 -> overflow=1; raise ack -> tokens 1,2,3,4 in order, then output_stb=0.
- Queue 2 tokens with PRESS active, then assert rst low mid-frame -> output_stb=0 immediately, col_n=4'b1110, overflow=0; after deassertion no stale tokens are emitted.
